sdq_queue: RTL



---
 rtl/sdq_pkg.sv | 19 +
 rtl/sdq_ram.sv | 25 ++
 rtl/sdq_queue.sv | 100 ++++++++++
 3 files changed

// File: rtl/sdq_pkg.sv
// Shared definitions for the LSU store-data queue: default geometry and
// width helpers for pointers and occupancy counters.
package sdq_pkg;

  localparam int unsigned SDQ_WIDTH = 64;
  localparam int unsigned SDQ_DEPTH = 17;

  function automatic int unsigned sdq_ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned sdq_cnt_bits(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [sdq_ptr_bits(SDQ_DEPTH)-1:0] ptr_t;
  typedef logic [sdq_cnt_bits(SDQ_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/sdq_ram.sv
// 1R1W synchronous-read storage array; the replacement boundary for the
// SRAM macro. Read data register holds while R0_en is low.
module sdq_ram
  import sdq_pkg::*;
#(
  parameter int unsigned WIDTH = SDQ_WIDTH,
  parameter int unsigned DEPTH = SDQ_DEPTH
) (
  input  logic                            W0_clk,
  input  logic [sdq_ptr_bits(DEPTH)-1:0]  R0_addr,
  input  logic                            R0_en,
  output logic [WIDTH-1:0]                R0_data,
  input  logic [sdq_ptr_bits(DEPTH)-1:0]  W0_addr,
  input  logic                            W0_en,
  input  logic [WIDTH-1:0]                W0_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge W0_clk) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) R0_data <= mem[R0_addr];
  end

endmodule

// File: rtl/sdq_queue.sv
// Store-data FIFO: SRAM-backed array plus a head stage so the consumer sees
// a registered head with full one-per-cycle throughput.
module sdq_queue
  import sdq_pkg::*;
#(
  parameter int unsigned WIDTH = SDQ_WIDTH,
  parameter int unsigned DEPTH = SDQ_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [WIDTH-1:0]             enq_data,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [WIDTH-1:0]             deq_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = sdq_ptr_bits(DEPTH);
  localparam int unsigned CW = sdq_cnt_bits(DEPTH);

  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    arr_cnt;
  logic             out_v;
  logic [WIDTH-1:0] out_q;
  logic             sel_ram;
  logic [WIDTH-1:0] ram_rdata;

  logic enq_fire, deq_fire, load, rd_en, bypass, wr_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    enq_ready = !flush && (count < CW'(DEPTH));
    enq_fire  = enq_valid && enq_ready;
    deq_fire  = out_v && deq_ready;
    load      = !out_v || deq_fire;
    rd_en     = !flush && load && (arr_cnt != '0);
    bypass    = load && (arr_cnt == '0) && enq_fire;
    wr_en     = enq_fire && !bypass;
  end

  // An array read counts as head-resident from the issue edge; the head is
  // then presented straight from the macro's read register, which holds
  // under back-pressure because no further read is issued until load.
  assign deq_valid = out_v;
  assign deq_data  = sel_ram ? ram_rdata : out_q;
  assign count     = arr_cnt + CW'(out_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      arr_cnt <= '0;
      out_v   <= 1'b0;
      out_q   <= '0;
      sel_ram <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      arr_cnt <= '0;
      out_v   <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en && !wr_en)      arr_cnt <= arr_cnt - 1'b1;
      else if (wr_en && !rd_en) arr_cnt <= arr_cnt + 1'b1;
      if (load) begin
        if (rd_en) begin
          out_v   <= 1'b1;
          sel_ram <= 1'b1;
        end else if (enq_fire) begin
          out_v   <= 1'b1;
          sel_ram <= 1'b0;
          out_q   <= enq_data;
        end else begin
          out_v   <= 1'b0;
        end
      end
    end
  end

  sdq_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .W0_clk  (clk),
    .R0_addr (rd_ptr),
    .R0_en   (rd_en),
    .R0_data (ram_rdata),
    .W0_addr (wr_ptr),
    .W0_en   (wr_en),
    .W0_data (enq_data)
  );

endmodule
